// File: rtl/mem_pkg.sv
// Shared types for the parametrised data memory: FSM states, latency bound,
// and a default-width response record.
package mem_pkg;

  localparam int RD_LAT_MAX  = 2;
  localparam int DFLT_DATA_W = 8;

  typedef enum logic {
    MEM_CLEAR,
    MEM_READY
  } mem_state_e;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [DFLT_DATA_W-1:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_array.sv
// Plain DEPTH x DATA_W single-port array: synchronous write, synchronous read.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Callers guarantee addr_i < DEPTH whenever we_i or re_i is set.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_data_memory.sv
// MEM-stage data memory: valid/ready requests, post-reset zero-fill,
// 1- or 2-cycle registered read responses with out-of-range flagging.
module param_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RD_LAT         = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_We,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data_in,
  output logic              Resp_Valid,
  output logic              Resp_Err,
  output logic [DATA_W-1:0] Data_out,
  output logic              Init_Done
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $fatal(1, "param_data_memory: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $fatal(1, "param_data_memory: DEPTH must be in 1..2**ADDR_W");
  end

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  mem_state_e        state_q;
  logic [ADDR_W:0]   clr_cnt_q;
  logic              rdy_q;
  logic              done_q;

  logic              clearing;
  logic              in_range;
  logic              acc_rd;
  logic              acc_wr;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic [RD_LAT-1:0] vld_pipe_q;
  logic [RD_LAT-1:0] err_pipe_q;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  assign clearing = (state_q == MEM_CLEAR) && !RST;
  assign in_range = {1'b0, Address} < DEPTH_C;
  assign acc_rd   = Req_Valid & rdy_q & ~Req_We & ~RST;
  assign acc_wr   = Req_Valid & rdy_q &  Req_We & ~RST;

  // Clear sequence and request path share the single array port.
  assign arr_we    = clearing | (acc_wr & in_range);
  assign arr_re    = acc_rd & in_range;
  assign arr_addr  = clearing ? clr_cnt_q[ADDR_W-1:0] : Address;
  assign arr_wdata = clearing ? '0 : Data_in;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= CLEAR_ON_RESET ? MEM_CLEAR : MEM_READY;
      clr_cnt_q <= '0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        MEM_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_C) begin
            state_q <= MEM_READY;
            rdy_q   <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          rdy_q  <= 1'b1;
          done_q <= 1'b1;
        end
      endcase
    end
  end

  // Bit i of each pipe is the request state i+1 cycles after acceptance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
    end else begin
      vld_pipe_q <= RD_LAT'({vld_pipe_q, acc_rd});
      err_pipe_q <= RD_LAT'({err_pipe_q, acc_rd & ~in_range});
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] data2_q;
    always_ff @(posedge CLK) begin
      data2_q <= arr_rdata;
    end
    assign out_data = data2_q;
  end else begin : g_lat1
    assign out_data = arr_rdata;
  end

  assign out_err    = err_pipe_q[RD_LAT-1];
  assign Resp_Valid = vld_pipe_q[RD_LAT-1];
  assign Resp_Err   = Resp_Valid & out_err;
  assign Data_out   = (Resp_Valid && !out_err) ? out_data : '0;
  assign Req_Ready  = rdy_q;
  assign Init_Done  = done_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench: four configurations side by side, a vector table on the
// default instance plus hand-written latency, range and reset sequences.
module tb_param_data_memory;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [4];
  logic       v    [4];
  logic       we   [4];
  logic [7:0] a    [4];
  logic [7:0] d    [4];
  logic       rdy  [4];
  logic       rv   [4];
  logic       re   [4];
  logic       dn   [4];
  logic [7:0] dout [4];

  int n_tests = 0;
  int n_fail  = 0;

  param_data_memory u0 (
    .CLK(clk), .RST(rst[0]), .Req_Valid(v[0]), .Req_Ready(rdy[0]), .Req_We(we[0]),
    .Address(a[0]), .Data_in(d[0]), .Resp_Valid(rv[0]), .Resp_Err(re[0]),
    .Data_out(dout[0]), .Init_Done(dn[0]));

  param_data_memory #(.RD_LAT(1), .CLEAR_ON_RESET(1'b0)) u1 (
    .CLK(clk), .RST(rst[1]), .Req_Valid(v[1]), .Req_Ready(rdy[1]), .Req_We(we[1]),
    .Address(a[1]), .Data_in(d[1]), .Resp_Valid(rv[1]), .Resp_Err(re[1]),
    .Data_out(dout[1]), .Init_Done(dn[1]));

  param_data_memory #(.RD_LAT(2), .CLEAR_ON_RESET(1'b0)) u2 (
    .CLK(clk), .RST(rst[2]), .Req_Valid(v[2]), .Req_Ready(rdy[2]), .Req_We(we[2]),
    .Address(a[2]), .Data_in(d[2]), .Resp_Valid(rv[2]), .Resp_Err(re[2]),
    .Data_out(dout[2]), .Init_Done(dn[2]));

  param_data_memory #(.DEPTH(200)) u3 (
    .CLK(clk), .RST(rst[3]), .Req_Valid(v[3]), .Req_Ready(rdy[3]), .Req_We(we[3]),
    .Address(a[3]), .Data_in(d[3]), .Resp_Valid(rv[3]), .Resp_Err(re[3]),
    .Data_out(dout[3]), .Init_Done(dn[3]));

  typedef struct {
    logic       v;
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    logic       ev;
    logic       ee;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int k, input logic vv, input logic ww,
                     input logic [7:0] aa, input logic [7:0] dd);
    v[k] = vv; we[k] = ww; a[k] = aa; d[k] = dd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with Req_Ready low, starting in the cycle right after reset release.
  task automatic wait_ready(input int k, output int n);
    n = 0;
    while (!rdy[k] && n < 1000) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'hA5};
    tbl[3]  = '{1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 8'hFF, 8'h5A, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h5A};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC3};
    tbl[9]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'hA5};
    tbl[12] = '{1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h3C};

    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      drv(k, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    step();
    step();

    // Reset state
    chk("rst_ready",  32'(rdy[0]),  32'd0);
    chk("rst_valid",  32'(rv[0]),   32'd0);
    chk("rst_err",    32'(re[0]),   32'd0);
    chk("rst_done",   32'(dn[0]),   32'd0);
    chk("rst_dout",   32'(dout[0]), 32'd0);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;

    // Full clear takes DEPTH cycles
    wait_ready(0, n);
    chk("t1_clear_cycles", 32'(n), 32'd256);
    chk("t1_init_done", 32'(dn[0]), 32'd1);
    chk("t4_ready_d200", 32'(rdy[3]), 32'd1);
    chk("t2_ready_noclr", 32'(rdy[1]), 32'd1);

    for (int i = 0; i < 14; i++) begin
      drv(0, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(rv[0]),   32'(tbl[i].ev));
      chk($sformatf("vec%0d_err", i),   32'(re[0]),   32'(tbl[i].ee));
      chk($sformatf("vec%0d_data", i),  32'(dout[0]), 32'(tbl[i].ed));
    end

    drv(0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d_valid", i), 32'(rv[0]), 32'd0);
    end

    // RD_LAT=1 without clear: write-then-read
    drv(1, 1'b1, 1'b1, 8'h10, 8'hA5);
    step();
    chk("t2_wr_noresp", 32'(rv[1]), 32'd0);
    drv(1, 1'b1, 1'b0, 8'h10, 8'h00);
    step();
    chk("t2_valid", 32'(rv[1]),   32'd1);
    chk("t2_data",  32'(dout[1]), 32'hA5);
    chk("t2_err",   32'(re[1]),   32'd0);
    drv(1, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("t2_idle_valid", 32'(rv[1]),   32'd0);
    chk("t2_idle_data",  32'(dout[1]), 32'd0);

    // RD_LAT=2 back-to-back reads
    drv(2, 1'b1, 1'b1, 8'h01, 8'h11); step();
    drv(2, 1'b1, 1'b1, 8'h02, 8'h22); step();
    drv(2, 1'b1, 1'b1, 8'h03, 8'h33); step();
    drv(2, 1'b1, 1'b0, 8'h01, 8'h00); step();
    chk("t3_lat_early", 32'(rv[2]), 32'd0);
    drv(2, 1'b1, 1'b0, 8'h02, 8'h00); step();
    chk("t3_r1_valid", 32'(rv[2]),   32'd1);
    chk("t3_r1_data",  32'(dout[2]), 32'h11);
    drv(2, 1'b1, 1'b0, 8'h03, 8'h00); step();
    chk("t3_r2_valid", 32'(rv[2]),   32'd1);
    chk("t3_r2_data",  32'(dout[2]), 32'h22);
    drv(2, 1'b0, 1'b0, 8'h00, 8'h00); step();
    chk("t3_r3_valid", 32'(rv[2]),   32'd1);
    chk("t3_r3_data",  32'(dout[2]), 32'h33);
    step();
    chk("t3_end_valid", 32'(rv[2]),   32'd0);
    chk("t3_end_data",  32'(dout[2]), 32'd0);

    // DEPTH=200 out-of-range
    drv(3, 1'b1, 1'b1, 8'd200, 8'hFF); step();
    drv(3, 1'b1, 1'b0, 8'd200, 8'h00); step();
    chk("t4_oor_valid", 32'(rv[3]),   32'd1);
    chk("t4_oor_err",   32'(re[3]),   32'd1);
    chk("t4_oor_data",  32'(dout[3]), 32'd0);
    drv(3, 1'b1, 1'b0, 8'd199, 8'h00); step();
    chk("t4_199_valid", 32'(rv[3]),   32'd1);
    chk("t4_199_err",   32'(re[3]),   32'd0);
    chk("t4_199_data",  32'(dout[3]), 32'd0);
    drv(3, 1'b1, 1'b0, 8'd72, 8'h00); step();
    chk("t4_alias72_data", 32'(dout[3]), 32'd0);
    drv(3, 1'b1, 1'b0, 8'd0, 8'h00); step();
    chk("t4_alias0_data", 32'(dout[3]), 32'd0);
    drv(3, 1'b0, 1'b0, 8'h00, 8'h00); step();
    chk("t4_idle_err", 32'(re[3]), 32'd0);

    // Reset mid-clear restarts from address 0
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("t5_midclr_ready", 32'(rdy[0]), 32'd0);
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    wait_ready(0, n);
    chk("t5_reclear_cycles", 32'(n), 32'd256);

    // Reset while a read is in flight drops the response
    drv(2, 1'b1, 1'b0, 8'h02, 8'h00); step();
    chk("t5_inflight_a", 32'(rv[2]), 32'd0);
    drv(2, 1'b0, 1'b0, 8'h00, 8'h00);
    rst[2] = 1'b1; step();
    chk("t5_inflight_b", 32'(rv[2]), 32'd0);
    rst[2] = 1'b0; step();
    chk("t5_inflight_c", 32'(rv[2]), 32'd0);
    step();
    chk("t5_inflight_d", 32'(rv[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
